// File: rtl/wb_stage_if.sv
// Bundle of MEM-to-WB inputs and register-bank write-port outputs for wb_stage.
// The slave modport is the stage itself; the master modport is whoever drives the MEM side.
interface wb_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 16
);
    logic                      i_stall;
    logic                      i_flush;
    logic                      i_valid;
    logic [1:0]                i_wb;
    logic                      i_link;
    logic [2:0]                i_ldtype;
    logic [DATA_WIDTH-1:0]     i_aluresult;
    logic [DATA_WIDTH-1:0]     i_readdata;
    logic [DATA_WIDTH-1:0]     i_pcplus;
    logic [REG_ADDR_WIDTH-1:0] i_rd;
    logic                      o_write;
    logic [REG_ADDR_WIDTH-1:0] o_writereg;
    logic [DATA_WIDTH-1:0]     o_writedata;
    logic                      o_valid;
    logic [COUNT_WIDTH-1:0]    o_retired;

    modport slave (
        input  i_stall, i_flush, i_valid, i_wb, i_link, i_ldtype,
               i_aluresult, i_readdata, i_pcplus, i_rd,
        output o_write, o_writereg, o_writedata, o_valid, o_retired
    );

    modport master (
        output i_stall, i_flush, i_valid, i_wb, i_link, i_ldtype,
               i_aluresult, i_readdata, i_pcplus, i_rd,
        input  o_write, o_writereg, o_writedata, o_valid, o_retired
    );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register, load byte/half formatting, result select,
// register-bank write port and a saturating retired-instruction counter.
module wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic      i_clock,
    input  logic      i_reset,
    wb_stage_if.slave bus
);
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    logic                      valid_p0;
    logic                      regwrite_p0;
    logic                      memtoreg_p0;
    logic                      link_p0;
    logic [2:0]                ldtype_p0;
    logic [DATA_WIDTH-1:0]     aluresult_p0;
    logic [DATA_WIDTH-1:0]     readdata_p0;
    logic [DATA_WIDTH-1:0]     pcplus_p0;
    logic [REG_ADDR_WIDTH-1:0] rd_p0;
    logic [COUNT_WIDTH-1:0]    retired;
    logic [DATA_WIDTH-1:0]     writedata;

    // Little-endian extraction; unknown load types fall back to a full word.
    function automatic logic [DATA_WIDTH-1:0] format_load(
        input logic [2:0]            ldtype,
        input logic [1:0]            off,
        input logic [DATA_WIDTH-1:0] word
    );
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        byte_s = word[{off, 3'b000} +: 8];
        half_s = off[1] ? word[31:16] : word[15:0];
        case (ldtype)
            LD_LH:   format_load = DATA_WIDTH'(half_s);
            LD_LHU:  format_load = DATA_WIDTH'($unsigned(half_s));
            LD_LB:   format_load = DATA_WIDTH'(byte_s);
            LD_LBU:  format_load = DATA_WIDTH'($unsigned(byte_s));
            default: format_load = word;
        endcase
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(
        input logic [COUNT_WIDTH-1:0] cnt,
        input logic                   en
    );
        if (en && (cnt != '1)) sat_inc = cnt + COUNT_WIDTH'(1);
        else                   sat_inc = cnt;
    endfunction

    // MEM/WB boundary: flush beats stall; the counter samples the slot before it changes.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            valid_p0     <= 1'b0;
            regwrite_p0  <= 1'b0;
            memtoreg_p0  <= 1'b0;
            link_p0      <= 1'b0;
            ldtype_p0    <= '0;
            aluresult_p0 <= '0;
            readdata_p0  <= '0;
            pcplus_p0    <= '0;
            rd_p0        <= '0;
            retired      <= '0;
        end else begin
            retired <= sat_inc(retired, valid_p0);
            if (bus.i_flush) begin
                valid_p0    <= 1'b0;
                regwrite_p0 <= 1'b0;
            end else if (!bus.i_stall) begin
                valid_p0     <= bus.i_valid;
                regwrite_p0  <= bus.i_wb[1];
                memtoreg_p0  <= bus.i_wb[0];
                link_p0      <= bus.i_link;
                ldtype_p0    <= bus.i_ldtype;
                aluresult_p0 <= bus.i_aluresult;
                readdata_p0  <= bus.i_readdata;
                pcplus_p0    <= bus.i_pcplus;
                rd_p0        <= bus.i_rd;
            end
        end
    end

    always_comb begin
        writedata = aluresult_p0;
        if (link_p0)          writedata = pcplus_p0;
        else if (memtoreg_p0) writedata = format_load(ldtype_p0, aluresult_p0[1:0], readdata_p0);
    end

    assign bus.o_write     = valid_p0 && regwrite_p0 && (rd_p0 != '0);
    assign bus.o_writereg  = rd_p0;
    assign bus.o_writedata = writedata;
    assign bus.o_valid     = valid_p0;
    assign bus.o_retired   = retired;
endmodule
